retire_stage: RTL and testbench
===============================

# retire_stage

In-order retirement stage of the R10K-style out-of-order core. It consumes the ROB head packet (`ROB_IR_PACKET`) and returns `ir_stall`, which gates the ROB head advance. Each committed instruction updates the architectural map, releases its old physical tag to the free list, and may perform a store through a data-memory request/acknowledge handshake, raise a squash for a taken branch, or halt the core. It also drives a registered writeback trace and a committed-instruction counter.

## Interface
- `CNT_W`, 64, width of the retired-instruction counter
- `clock`  in  1  core clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; overrides every other input
- `rob_ir_packet`  in  ROB_IR_PACKET  head entry: `retire_en`, `retire_t`, `retire_t_old`, `inst`, `halt`, `wr_mem`, `dest_reg_idx`, `NPC`, `result`, `rs2_value`, `take_branch`
- `dmem_ack`  in  1  memory accepted the store presented this cycle
- `ir_stall`  out  1  head must not advance this cycle
- `arch_wr_en` / `arch_wr_idx` / `arch_wr_tag`  out  1/5/TAG  architectural map write
- `free_en` / `free_tag`  out  1/TAG  return `retire_t_old` to the free list
- `squash` / `squash_target`  out  1/`XLEN`  taken-branch flush and redirect PC
- `dmem_req` / `dmem_addr` / `dmem_data` / `dmem_size`  out  1/`XLEN`/`XLEN`/MEM_SIZE  store request
- `halted`  out  1  sticky halt
- `retired_count`  out  `CNT_W`  committed instructions
- `wb_valid` / `wb_pc` / `wb_reg` / `wb_data`  out  1/`XLEN`/5/`XLEN`  registered trace of the previous cycle's commit

## Operation
- States: IDLE, STORE_WAIT, HALTED.
- A commit fires in a cycle iff `retire_en && !ir_stall`. All commit outputs are combinational in that cycle.
- IDLE, `retire_en=0`: `ir_stall=0`, no outputs are asserted.
- IDLE, non-store head: the commit fires immediately.
- IDLE, store head (`wr_mem=1`): `ir_stall=1`. The block registers `dmem_addr=result`, `dmem_data=rs2_value`, and `dmem_size` from `inst.r.funct3[1:0]` (0 byte, 1 half, 2 word), then moves to STORE_WAIT.
- STORE_WAIT: `dmem_req=1` with the request fields held stable. `ir_stall = !dmem_ack`. On `dmem_ack`, the commit fires and the state returns to IDLE.
- Commit side effects:
  - `arch_wr_en=free_en=1` iff `dest_reg_idx!=0`; `arch_wr_idx=dest_reg_idx`, `arch_wr_tag=retire_t`, `free_tag=retire_t_old`.
  - `take_branch=1`: `squash=1`, `squash_target=result`.
  - `halt=1`: next state is HALTED.
  - `retired_count` increments by 1 (wraps modulo 2^CNT_W).
- HALTED: `ir_stall=1` unconditionally, `halted=1`, no further commits. Only reset exits this state.
- Trace: on the edge after a commit, `wb_valid=1`, `wb_pc=NPC-4`, `wb_reg=dest_reg_idx`, `wb_data=result`. Otherwise `wb_valid=0`.

## Timing
- Reset: state IDLE. Every output is 0: `ir_stall`, `dmem_req`, `squash`, `halted`, `arch_wr_en`, `free_en`, `wb_valid`, `retired_count`, and all data fields.
- Non-store commit: 0 extra cycles; the head advances on the same edge.
- Store commit: minimum 2 cycles (request-capture cycle, then ack cycle). Each cycle without `dmem_ack` adds one cycle.
- `squash` is asserted in the commit cycle only. The ROB clears on that edge, so the following cycle sees `retire_en=0`.
- A store and a taken branch cannot occupy the same entry. If `wr_mem` and `take_branch` are both set, the store path runs and `squash` is asserted at the ack commit.
- Reset during STORE_WAIT drops `dmem_req` on the next cycle and discards the pending store.
- `dmem_ack` outside STORE_WAIT is ignored.
- A halting store completes its ack before the state enters HALTED.

## Test plan
- Reset, then an ALU head with `dest=5, t=12, t_old=3` -> same cycle: `ir_stall=0`, arch write (5,12), free 3. Next cycle: `wb_valid=1`, `retired_count=1`.
- Store head with `result=0x100, rs2_value=0xAB, funct3=0`; ack withheld 3 cycles -> `ir_stall=1` for 4 cycles, `dmem_req` held with addr 0x100, data 0xAB, BYTE. The commit fires on the ack cycle.
- Taken branch with `result=0x2000` -> `squash=1` and `squash_target=0x2000` for one cycle; `free_en=0` when dest is 0.
- Halt head -> the commit fires, `halted=1`, and `ir_stall` stays 1 while further `retire_en` is presented; `retired_count` stays frozen.
- Reset asserted in STORE_WAIT -> next cycle `dmem_req=0`, state IDLE, `retired_count=0`.
- Back-to-back ALU heads for 10 cycles -> 10 commits, `retired_count=10`, no stall cycles.

Source files
------------

// File: rtl/retire_stage.sv
// retire_stage: in-order commit of the ROB head.
// Maps, frees, stores via req/ack, squashes, halts, traces.

package retire_pkg;
    localparam int XLEN  = 32;
    localparam int TAG_W = 6;

    typedef enum logic [1:0] {
        BYTE   = 2'h0,
        HALF   = 2'h1,
        WORD   = 2'h2,
        DOUBLE = 2'h3
    } MEM_SIZE;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } R_TYPE;

    typedef union packed {
        logic [31:0] bits;
        R_TYPE       r;
    } INST;

    typedef struct packed {
        logic             retire_en;
        logic [TAG_W-1:0] retire_t;
        logic [TAG_W-1:0] retire_t_old;
        INST              inst;
        logic             halt;
        logic             wr_mem;
        logic [4:0]       dest_reg_idx;
        logic [XLEN-1:0]  NPC;
        logic [XLEN-1:0]  result;
        logic [XLEN-1:0]  rs2_value;
        logic             take_branch;
    } ROB_IR_PACKET;
endpackage

module retire_stage
    import retire_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  ROB_IR_PACKET     rob_ir_packet,
    input  logic             dmem_ack,
    output logic             ir_stall,
    output logic             arch_wr_en,
    output logic [4:0]       arch_wr_idx,
    output logic [TAG_W-1:0] arch_wr_tag,
    output logic             free_en,
    output logic [TAG_W-1:0] free_tag,
    output logic             squash,
    output logic [XLEN-1:0]  squash_target,
    output logic             dmem_req,
    output logic [XLEN-1:0]  dmem_addr,
    output logic [XLEN-1:0]  dmem_data,
    output MEM_SIZE          dmem_size,
    output logic             halted,
    output logic [CNT_W-1:0] retired_count,
    output logic             wb_valid,
    output logic [XLEN-1:0]  wb_pc,
    output logic [4:0]       wb_reg,
    output logic [XLEN-1:0]  wb_data
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        STORE_WAIT = 2'd1,
        HALTED     = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             capture;
    logic             commit;
    logic [XLEN-1:0]  addr_q;
    logic [XLEN-1:0]  data_q;
    MEM_SIZE          size_q;
    logic [CNT_W-1:0] count_q;
    logic             wbv_q;
    logic [XLEN-1:0]  wbpc_q;
    logic [4:0]       wbreg_q;
    logic [XLEN-1:0]  wbdata_q;
    logic             unused_inst;

    assign unused_inst = ^{rob_ir_packet.inst.r.funct7,
                           rob_ir_packet.inst.r.rs2,
                           rob_ir_packet.inst.r.rs1,
                           rob_ir_packet.inst.r.funct3[2],
                           rob_ir_packet.inst.r.rd,
                           rob_ir_packet.inst.r.opcode};

    // Head stall: store capture, ack wait, or halted forever
    always_comb begin
        ir_stall = 1'b0;
        unique case (state_q)
            IDLE:       ir_stall = rob_ir_packet.retire_en
                                 && rob_ir_packet.wr_mem;
            STORE_WAIT: ir_stall = !dmem_ack;
            HALTED:     ir_stall = 1'b1;
            default:    ir_stall = 1'b0;
        endcase
        if (reset) ir_stall = 1'b0;
    end

    assign commit = !reset && rob_ir_packet.retire_en && !ir_stall;

    // Next state and store-capture strobe
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (commit && rob_ir_packet.halt) begin
                    state_d = HALTED;
                end else if (rob_ir_packet.retire_en
                             && rob_ir_packet.wr_mem) begin
                    state_d = STORE_WAIT;
                    capture = 1'b1;
                end
            end
            STORE_WAIT: begin
                if (dmem_ack) begin
                    state_d = (commit && rob_ir_packet.halt)
                            ? HALTED : IDLE;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    // Combinational commit side effects, zero when nothing commits
    always_comb begin
        arch_wr_en    = 1'b0;
        arch_wr_idx   = '0;
        arch_wr_tag   = '0;
        free_en       = 1'b0;
        free_tag      = '0;
        squash        = 1'b0;
        squash_target = '0;
        if (commit) begin
            arch_wr_en  = rob_ir_packet.dest_reg_idx != 5'd0;
            free_en     = rob_ir_packet.dest_reg_idx != 5'd0;
            arch_wr_idx = rob_ir_packet.dest_reg_idx;
            arch_wr_tag = rob_ir_packet.retire_t;
            free_tag    = rob_ir_packet.retire_t_old;
            if (rob_ir_packet.take_branch) begin
                squash        = 1'b1;
                squash_target = rob_ir_packet.result;
            end
        end
    end

    // State register and held store request fields
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            size_q  <= BYTE;
        end else begin
            state_q <= state_d;
            if (capture) begin
                addr_q <= rob_ir_packet.result;
                data_q <= rob_ir_packet.rs2_value;
                size_q <= MEM_SIZE'(rob_ir_packet.inst.r.funct3[1:0]);
            end
        end
    end

    // Retired counter and one-cycle-late writeback trace
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q  <= '0;
            wbv_q    <= 1'b0;
            wbpc_q   <= '0;
            wbreg_q  <= '0;
            wbdata_q <= '0;
        end else begin
            wbv_q <= commit;
            if (commit) begin
                count_q  <= count_q + CNT_W'(1);
                wbpc_q   <= rob_ir_packet.NPC - XLEN'(4);
                wbreg_q  <= rob_ir_packet.dest_reg_idx;
                wbdata_q <= rob_ir_packet.result;
            end
        end
    end

    assign dmem_req      = state_q == STORE_WAIT;
    assign dmem_addr     = addr_q;
    assign dmem_data     = data_q;
    assign dmem_size     = size_q;
    assign halted        = state_q == HALTED;
    assign retired_count = count_q;
    assign wb_valid      = wbv_q;
    assign wb_pc         = wbpc_q;
    assign wb_reg        = wbreg_q;
    assign wb_data       = wbdata_q;

endmodule

// File: tb/tb_retire_stage.sv
// tb_retire_stage: scoreboard bench for retire_stage.
// Expected commits queued at drive time, popped at commit.

module tb_retire_stage;
    import retire_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    ROB_IR_PACKET     pkt;
    logic             ack;
    logic             ir_stall;
    logic             arch_wr_en;
    logic [4:0]       arch_wr_idx;
    logic [TAG_W-1:0] arch_wr_tag;
    logic             free_en;
    logic [TAG_W-1:0] free_tag;
    logic             squash;
    logic [XLEN-1:0]  squash_target;
    logic             dmem_req;
    logic [XLEN-1:0]  dmem_addr;
    logic [XLEN-1:0]  dmem_data;
    MEM_SIZE          dmem_size;
    logic             halted;
    logic [63:0]      retired_count;
    logic             wb_valid;
    logic [XLEN-1:0]  wb_pc;
    logic [4:0]       wb_reg;
    logic [XLEN-1:0]  wb_data;

    retire_stage #(.CNT_W(64)) dut (
        .clock(clk), .reset(reset),
        .rob_ir_packet(pkt), .dmem_ack(ack),
        .ir_stall(ir_stall),
        .arch_wr_en(arch_wr_en), .arch_wr_idx(arch_wr_idx),
        .arch_wr_tag(arch_wr_tag),
        .free_en(free_en), .free_tag(free_tag),
        .squash(squash), .squash_target(squash_target),
        .dmem_req(dmem_req), .dmem_addr(dmem_addr),
        .dmem_data(dmem_data), .dmem_size(dmem_size),
        .halted(halted), .retired_count(retired_count),
        .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_reg(wb_reg), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             wen;
        logic [4:0]       idx;
        logic [TAG_W-1:0] t;
        logic [TAG_W-1:0] told;
        logic             sq;
        logic [XLEN-1:0]  tgt;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  data;
    } exp_t;

    exp_t eq[$];
    exp_t tq[$];
    int   nvec = 0;
    int   nerr = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic head(input logic [4:0] dest, input int t,
                        input int told, input logic [31:0] npc,
                        input logic [31:0] res, input logic [31:0] rs2,
                        input bit hlt, input bit wr, input bit br,
                        input logic [2:0] f3, input bit push);
        exp_t e;
        pkt                 = '0;
        pkt.retire_en       = 1'b1;
        pkt.retire_t        = TAG_W'(t);
        pkt.retire_t_old    = TAG_W'(told);
        pkt.inst.r.funct3   = f3;
        pkt.inst.r.opcode   = wr ? 7'h23 : 7'h33;
        pkt.halt            = hlt;
        pkt.wr_mem          = wr;
        pkt.dest_reg_idx    = dest;
        pkt.NPC             = npc;
        pkt.result          = res;
        pkt.rs2_value       = rs2;
        pkt.take_branch     = br;
        if (push) begin
            e.wen  = dest != 5'd0;
            e.idx  = dest;
            e.t    = TAG_W'(t);
            e.told = TAG_W'(told);
            e.sq   = br;
            e.tgt  = br ? res : 32'd0;
            e.pc   = npc - 32'd4;
            e.data = res;
            eq.push_back(e);
        end
    endtask

    task automatic idle();
        pkt = '0;
    endtask

    // Monitor: compare trace of last commit, then any commit now
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            tq.delete();
        end else begin
            if (tq.size() != 0) begin
                e = tq.pop_front();
                chk("wb_valid", wb_valid, 1);
                chk("wb_pc", wb_pc, e.pc);
                chk("wb_reg", wb_reg, e.idx);
                chk("wb_data", wb_data, e.data);
            end else begin
                chk("wb_idle", wb_valid, 0);
            end
            if (pkt.retire_en && !ir_stall) begin
                if (eq.size() == 0) begin
                    chk("unexpected_commit", 1, 0);
                end else begin
                    e = eq.pop_front();
                    chk("arch_wr_en", arch_wr_en, e.wen);
                    chk("free_en", free_en, e.wen);
                    chk("arch_wr_idx", arch_wr_idx, e.idx);
                    chk("arch_wr_tag", arch_wr_tag, e.t);
                    chk("free_tag", free_tag, e.told);
                    chk("squash", squash, e.sq);
                    chk("squash_tgt", squash_target, e.tgt);
                    tq.push_back(e);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        ack   = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_stall", ir_stall, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_squash", squash, 0);
        chk("rst_halted", halted, 0);
        chk("rst_wen", arch_wr_en, 0);
        chk("rst_free", free_en, 0);
        chk("rst_count", retired_count, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_data", dmem_data, 0);
        chk("rst_wbpc", wb_pc, 0);

        // plain ALU commit
        @(posedge clk); #1;
        head(5, 12, 3, 32'h104, 32'h55, 0, 0, 0, 0, 3'd0, 1);
        @(negedge clk);
        chk("alu_stall", ir_stall, 0);
        @(posedge clk); #1 idle();
        @(negedge clk);
        chk("alu_count", retired_count, 1);

        // store: ack in capture cycle ignored, then 3 withheld
        @(posedge clk); #1;
        head(0, 7, 8, 32'h204, 32'h100, 32'hAB, 0, 1, 0, 3'd0, 1);
        ack = 1'b1;
        @(negedge clk);
        chk("st_cap_stall", ir_stall, 1);
        chk("st_cap_req", dmem_req, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1 ack = 1'b0;
            @(negedge clk);
            chk("st_wait_stall", ir_stall, 1);
            chk("st_req", dmem_req, 1);
            chk("st_addr", dmem_addr, 32'h100);
            chk("st_data", dmem_data, 32'hAB);
            chk("st_size", dmem_size, BYTE);
        end
        @(posedge clk); #1 ack = 1'b1;
        @(negedge clk);
        chk("st_ack_stall", ir_stall, 0);
        chk("st_ack_req", dmem_req, 1);
        chk("st_ack_count", retired_count, 1);
        @(posedge clk); #1 ack = 1'b0; idle();
        @(negedge clk);
        chk("st_done_req", dmem_req, 0);
        chk("st_count", retired_count, 2);

        // taken branch to x0
        @(posedge clk); #1;
        head(0, 9, 10, 32'h304, 32'h2000, 0, 0, 0, 1, 3'd0, 1);
        @(negedge clk);
        chk("br_free", free_en, 0);
        @(posedge clk); #1 idle();
        @(negedge clk);
        chk("br_sq_drop", squash, 0);
        chk("br_count", retired_count, 3);

        // ten back-to-back ALU heads
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            head(5'(i + 1), 20 + i, 40 + i, 32'h404 + 32'(4 * i),
                 32'(3 * i + 1), 0, 0, 0, 0, 3'd0, 1);
            @(negedge clk);
            chk("b2b_stall", ir_stall, 0);
        end
        @(posedge clk); #1 idle();
        @(negedge clk);
        chk("b2b_count", retired_count, 13);

        // halt, then further heads are refused
        @(posedge clk); #1;
        head(2, 30, 31, 32'h504, 32'h77, 0, 1, 0, 0, 3'd0, 1);
        @(negedge clk);
        chk("halt_stall", ir_stall, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            head(3, 1, 2, 32'h604, 32'h1, 0, 0, 0, 0, 3'd0, 0);
            ack = i[0];
            @(negedge clk);
            chk("hlt_stall", ir_stall, 1);
            chk("hlt_flag", halted, 1);
            chk("hlt_wen", arch_wr_en, 0);
            chk("hlt_count", retired_count, 14);
        end

        // reset exits halt; then reset during STORE_WAIT
        @(posedge clk); #1 idle(); ack = 1'b0; reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rst2_halted", halted, 0);
        chk("rst2_count", retired_count, 0);
        @(posedge clk); #1;
        head(0, 4, 5, 32'h704, 32'h300, 32'h12, 0, 1, 0, 3'd2, 0);
        @(negedge clk);
        chk("rs_cap_stall", ir_stall, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rs_req", dmem_req, 1);
        chk("rs_size", dmem_size, WORD);
        @(posedge clk); #1 reset = 1'b1; idle();
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rs_req_drop", dmem_req, 0);
        chk("rs_count", retired_count, 0);
        chk("rs_stall", ir_stall, 0);
        @(posedge clk); #1;
        head(6, 11, 13, 32'h804, 32'h9, 0, 0, 0, 0, 3'd0, 1);
        @(negedge clk);
        chk("rs_idle_commit", ir_stall, 0);
        @(posedge clk); #1 idle();
        @(negedge clk);
        chk("rs_post_count", retired_count, 1);

        @(posedge clk);
        @(negedge clk);
        chk("sb_empty", eq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule
